serial_adder: RTL and testbench
===============================

# serial_adder

Digit-serial multi-word adder that sits directly upstream of the 2-bit `full_adder` digit adder and drives it. It accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake. It then feeds the operands to one `full_adder` instance two bits per cycle, LSB digit first, and registers the digit carry between cycles. It assembles the WIDTH-bit sum and final carry-out and presents them through a valid/ready output handshake.

## Interface
- WIDTH, 8, operand/sum width in bits; must be even and ≥ 2
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset; asynchronous, active-high
- i_valid  input  1  operands valid
- o_ready  output  1  block can accept operands
- i_a  input  WIDTH  operand A, unsigned
- i_b  input  WIDTH  operand B, unsigned
- i_carry  input  1  carry-in
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_sum  output  WIDTH  sum bits
- o_carry  output  1  carry-out of bit WIDTH-1
- o_overflow  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN

## Operation
- States: S_IDLE, S_RUN, S_DONE. Reset state is S_IDLE.
- S_IDLE
  - o_ready=1.
  - On i_valid & o_ready: latch i_a and i_b into right-shift registers, latch i_carry into the carry register, and clear the digit counter.
  - Go to S_RUN.
- S_RUN, each cycle:
  - The adder receives a_sh[1:0], b_sh[1:0] and carry_reg.
  - a_sh and b_sh shift right by 2.
  - The sum register shifts right by 2, with the adder's o_sum inserted at [WIDTH-1:WIDTH-2].
  - carry_reg ← adder o_carry, and count++.
- Leave S_RUN when count reaches WIDTH/2-1 on a RUN edge, i.e. after exactly WIDTH/2 digit cycles. Go to S_DONE.
- S_DONE
  - o_valid=1. o_sum = sum register, o_carry = carry_reg.
  - Both are held stable until i_ready.
  - On i_ready: go to S_IDLE. The sum and carry registers keep their value.
- o_ready=1 only in S_IDLE. o_valid=1 only in S_DONE. Both are pure state decodes (registered state, no combinational path from inputs).
- i_valid outside S_IDLE is ignored, with no side effects.
- Arithmetic: {o_carry,o_sum} = i_a + i_b + i_carry, modulo 2^(WIDTH+1). No truncation is possible.
- Digit counter width: $clog2(WIDTH/2)+1.
- Reset, including mid-S_RUN or S_DONE:
  - Registers clear immediately and asynchronously: operand shift registers, sum, carry_reg and count go to 0, and state goes to S_IDLE.
  - Any in-flight result is discarded and never presented.
- Reset values: o_ready=1, o_valid=0, o_sum=0, o_carry=0, o_overflow=0.
- No acceptance occurs while i_rst=1.

## Timing
- Acceptance edge E0. Digit i (bits 2i+1:2i) is computed in the cycle after edge E(i) and registered at edge E(i+1).
- o_valid rises after edge E(WIDTH/2), giving a latency of WIDTH/2 cycles from acceptance.
- Minimum occupancy is WIDTH/2+2 cycles per operation (IDLE + RUN×WIDTH/2 + DONE). For WIDTH=8 this is 6 cycles.
- Backpressure: S_DONE persists indefinitely while i_ready=0, with outputs unchanged.
- A result is transferred on the edge where o_valid & i_ready. o_ready is high in the following cycle.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - The o_overflow port exists.
  - At acceptance, latch i_a[WIDTH-1] and i_b[WIDTH-1].
  - In S_DONE, o_overflow = (a_msb == b_msb) & (o_sum[WIDTH-1] != a_msb). It is 0 outside S_DONE.
- SERIAL_ADDER_OVF_EN undefined: no o_overflow port and no MSB latches. All other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the state typedef: 2-bit enum S_IDLE=0, S_RUN=1, S_DONE=2
  - DIGIT_W=2
  - DIGITS function (WIDTH/DIGIT_W)
- Sub-module: exactly one instance of the existing 2-bit `full_adder`. All digit arithmetic goes through it, with no duplicate adder logic in this block.

## Test plan
- WIDTH=8, A=0x2A, B=0x15, carry 0 → o_sum=0x3F, o_carry=0. o_valid rises exactly 4 cycles after the acceptance edge.
- A=0xFF, B=0x01, carry 0 → o_sum=0x00, o_carry=1. Also A=0xFF, B=0xFF, carry 1 → o_sum=0xFF, o_carry=1.
- Backpressure: complete 0x10+0x20, hold i_ready=0 for 5 cycles, and pulse i_valid with 0xAA/0x55.
  - Required: o_sum stays 0x30, o_ready=0, and the pulsed request is ignored.
  - After i_ready=1: one transfer, then o_ready=1.
- Reset mid-run: assert i_rst 2 cycles into S_RUN.
  - Required during reset: o_valid=0, o_sum=0, o_ready=1, with no result later.
  - After release: 0x01+0x01 → 0x02.
- Back-to-back: 3 operations with i_valid and i_ready held high.
  - Required: each result is correct and occupancy is 6 cycles per operation.
- With SERIAL_ADDER_OVF_EN:
  - 0x7F+0x01 → o_sum=0x80, o_overflow=1.
  - 0x80+0xFF → o_sum=0x7F, o_carry=1, o_overflow=1.
  - 0x05+0x03 → o_overflow=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the digit-serial adder
//
// Purpose: state encoding, digit width and digit-count helper used by
//          serial_adder and its testbench.
// Contents:
//   state_t  2-bit FSM state enum (S_IDLE=0, S_RUN=1, S_DONE=2)
//   DIGIT_W  bits processed per cycle
//   DIGITS() number of digit cycles for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  function automatic int DIGITS(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - 2-bit digit full adder driven by serial_adder
//
// Purpose: adds two 2-bit digits plus a carry-in.
// Ports:
//   i_a[1:0], i_b[1:0]  digit operands
//   i_carry             carry-in
//   o_sum[1:0]          digit sum
//   o_carry             carry-out of bit 1
module full_adder (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_carry,
  output logic [1:0] o_sum,
  output logic       o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {2'b00, i_carry};

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial WIDTH-bit adder, two bits per cycle
//
// Purpose: accepts A, B and carry-in over a valid/ready handshake, adds them
//          LSB digit first through one 2-bit full_adder, and presents the
//          WIDTH-bit sum and carry-out over a valid/ready handshake.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds o_overflow, signed overflow).
// Ports:
//   i_clk, i_rst           clock; asynchronous active-high reset
//   i_valid / o_ready      operand handshake (o_ready high only in S_IDLE)
//   i_a, i_b, i_carry      operands and carry-in
//   o_valid / i_ready      result handshake (o_valid high only in S_DONE)
//   o_sum, o_carry         result and carry-out
//   o_overflow             signed overflow (SERIAL_ADDER_OVF_EN only)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int NDIG  = DIGITS(WIDTH);
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_shifted;
  logic             carry_reg;
  logic [CNT_W-1:0] count;
  logic [1:0]       fa_sum;
  logic             fa_carry;

  full_adder u_full_adder (
    .i_a     (a_sh[1:0]),
    .i_b     (b_sh[1:0]),
    .i_carry (carry_reg),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // New digit enters at the top; after NDIG shifts digit 0 sits at [1:0].
  // Concatenate-then-shift keeps this legal even when WIDTH == 2.
  assign sum_shifted = WIDTH'({fa_sum, sum_reg} >> DIGIT_W);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_valid)              state_next = S_RUN;
      S_RUN:   if (count == LAST_DIGIT)  state_next = S_DONE;
      S_DONE:  if (i_ready)              state_next = S_IDLE;
      default:                           state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      count     <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            a_sh      <= i_a;
            b_sh      <= i_b;
            carry_reg <= i_carry;
            count     <= '0;
          end
        end
        S_RUN: begin
          a_sh      <= a_sh >> DIGIT_W;
          b_sh      <= b_sh >> DIGIT_W;
          sum_reg   <= sum_shifted;
          carry_reg <= fa_carry;
          count     <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);
  assign o_sum   = sum_reg;
  assign o_carry = carry_reg;

`ifdef SERIAL_ADDER_OVF_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are shifted out during S_RUN, so they are kept aside.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (state == S_IDLE && i_valid) begin
      a_msb <= i_a[WIDTH-1];
      b_msb <= i_b[WIDTH-1];
    end
  end

  assign o_overflow = (state == S_DONE) && (a_msb == b_msb) && (sum_reg[WIDTH-1] != a_msb);
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_carry;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_sum;
  logic       o_carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic       o_overflow;
`endif

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  serial_adder #(.WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_carry    (i_carry),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_carry    (o_carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .o_overflow (o_overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand set in S_IDLE and returns at the negedge where
  // o_valid was first seen; lat = edges from acceptance to o_valid.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    @(negedge i_clk);
    i_a = a; i_b = b; i_carry = c; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    int last_cyc;
    int cyc;
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic       vc [3];
    logic [8:0] vr [3];

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    i_a = '0; i_b = '0; i_carry = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_sum",   32'(o_sum),   0);
    check("rst_carry", 32'(o_carry), 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",   32'(o_overflow), 0);
`endif
    i_valid = 1'b1; i_a = 8'h12; i_b = 8'h34;
    @(posedge i_clk);
    @(negedge i_clk);
    check("no_accept_in_reset", 32'(o_ready), 1);
    i_valid = 1'b0;
    i_rst = 1'b0;

    // 0x2A + 0x15
    start_op(8'h2A, 8'h15, 1'b0, lat);
    check("t1_latency", 32'(lat), 4);
    check("t1_sum",   32'(o_sum),   32'h3F);
    check("t1_carry", 32'(o_carry), 0);
    check("t1_ready_low", 32'(o_ready), 0);
    finish_op();
    check("t1_ready_after", 32'(o_ready), 1);
    check("t1_valid_after", 32'(o_valid), 0);

    // 0xFF + 0x01
    start_op(8'hFF, 8'h01, 1'b0, lat);
    check("t2_valid", 32'(o_valid), 1);
    check("t2_sum",   32'(o_sum),   32'h00);
    check("t2_carry", 32'(o_carry), 1);
    finish_op();

    // 0xFF + 0xFF + 1
    start_op(8'hFF, 8'hFF, 1'b1, lat);
    check("t3_valid", 32'(o_valid), 1);
    check("t3_sum",   32'(o_sum),   32'hFF);
    check("t3_carry", 32'(o_carry), 1);
    finish_op();

    // Backpressure with an ignored request pulse
    start_op(8'h10, 8'h20, 1'b0, lat);
    check("bp_valid", 32'(o_valid), 1);
    for (int k = 0; k < 5; k++) begin
      i_valid = (k == 2); i_a = 8'hAA; i_b = 8'h55;
      @(negedge i_clk);
      check("bp_hold_sum",   32'(o_sum),   32'h30);
      check("bp_hold_ready", 32'(o_ready), 0);
      check("bp_hold_valid", 32'(o_valid), 1);
    end
    i_valid = 1'b0;
    finish_op();
    check("bp_ready_after", 32'(o_ready), 1);
    check("bp_valid_after", 32'(o_valid), 0);
    check("bp_sum_kept",    32'(o_sum),   32'h30);

    // Reset two cycles into S_RUN
    @(negedge i_clk);
    i_a = 8'h33; i_b = 8'h11; i_carry = 1'b0; i_valid = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check("mr_valid", 32'(o_valid), 0);
    check("mr_sum",   32'(o_sum),   0);
    check("mr_ready", 32'(o_ready), 1);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("mr_no_result", 32'(seen), 0);
    start_op(8'h01, 8'h01, 1'b0, lat);
    check("mr_after_valid", 32'(o_valid), 1);
    check("mr_after_sum",   32'(o_sum),   32'h02);
    finish_op();

    // Back-to-back with handshakes held high
    va[0] = 8'h01; vb[0] = 8'h02; vc[0] = 1'b0; vr[0] = 9'h003;
    va[1] = 8'h80; vb[1] = 8'h80; vc[1] = 1'b1; vr[1] = 9'h101;
    va[2] = 8'h5A; vb[2] = 8'hA5; vc[2] = 1'b0; vr[2] = 9'h0FF;
    @(negedge i_clk);
    i_a = va[0]; i_b = vb[0]; i_carry = vc[0];
    i_valid = 1'b1; i_ready = 1'b1;
    seen = 0; last_cyc = 0; cyc = 0;
    while (seen < 3 && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      if (o_valid) begin
        check("b2b_sum",   32'(o_sum),   32'(vr[seen][7:0]));
        check("b2b_carry", 32'(o_carry), 32'(vr[seen][8]));
        if (seen > 0) check("b2b_occupancy", 32'(cyc - last_cyc), 6);
        last_cyc = cyc;
        seen++;
        if (seen < 3) begin
          i_a = va[seen]; i_b = vb[seen]; i_carry = vc[seen];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(seen), 3);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("b2b_idle", 32'(o_ready), 1);

`ifdef SERIAL_ADDER_OVF_EN
    start_op(8'h7F, 8'h01, 1'b0, lat);
    check("ovf1_sum", 32'(o_sum), 32'h80);
    check("ovf1_ovf", 32'(o_overflow), 1);
    finish_op();
    check("ovf1_idle_ovf", 32'(o_overflow), 0);
    start_op(8'h80, 8'hFF, 1'b0, lat);
    check("ovf2_sum",   32'(o_sum),   32'h7F);
    check("ovf2_carry", 32'(o_carry), 1);
    check("ovf2_ovf",   32'(o_overflow), 1);
    finish_op();
    start_op(8'h05, 8'h03, 1'b0, lat);
    check("ovf3_sum", 32'(o_sum), 32'h08);
    check("ovf3_ovf", 32'(o_overflow), 0);
    finish_op();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
